// File: rtl/bcd_time_counter_if.sv
// Bundle for the time counter's controls and its time display outputs.
// The slave side is the counter; the master side is the button/renderer side.
interface bcd_time_counter_if;
    logic       set_mode;
    logic       btn_hr;
    logic       btn_min;
    logic       tick_1Hz;
    logic [3:0] sec_1s;
    logic [3:0] sec_10s;
    logic [3:0] min_1s;
    logic [3:0] min_10s;
    logic [3:0] hr_1s;
    logic [3:0] hr_10s;
    logic       pm;

    modport master (
        output set_mode, btn_hr, btn_min,
        input  tick_1Hz, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s, pm
    );

    modport slave (
        input  set_mode, btn_hr, btn_min,
        output tick_1Hz, sec_1s, sec_10s, min_1s, min_10s, hr_1s, hr_10s, pm
    );
endinterface

// File: rtl/bcd_time_counter.sv
// 12-hour BCD timekeeper: divides clk to a 1 Hz tick, ripples seconds into
// minutes and hours, and supports a halted set mode driven by two buttons.
module bcd_time_counter #(
    parameter int CLK_HZ = 100_000_000
) (
    input  logic             clk,
    input  logic             reset,
    bcd_time_counter_if.slave bus
);
    localparam int PW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_HZ - 1);

    // Returns {carry, tens, ones} for a 00..59 BCD field advanced by one.
    function automatic logic [8:0] bcd60_inc(input logic [3:0] tens, input logic [3:0] ones);
        logic [8:0] res;
        if (ones == 4'd9) begin
            if (tens == 4'd5) begin
                res = {1'b1, 4'd0, 4'd0};
            end else begin
                res = {1'b0, tens + 4'd1, 4'd0};
            end
        end else begin
            res = {1'b0, tens, ones + 4'd1};
        end
        return res;
    endfunction

    // Returns {pm, hr_10s, hr_1s} for the 12,01..11,12 sequence; 11->12 flips pm.
    function automatic logic [8:0] hour_inc(input logic [3:0] h10, input logic [3:0] h1,
                                            input logic p);
        logic [8:0] res;
        if ((h10 == 4'd1) && (h1 == 4'd1)) begin
            res = {~p, 4'd1, 4'd2};
        end else if ((h10 == 4'd1) && (h1 == 4'd2)) begin
            res = {p, 4'd0, 4'd1};
        end else if (h1 == 4'd9) begin
            res = {p, 4'd1, 4'd0};
        end else begin
            res = {p, h10, h1 + 4'd1};
        end
        return res;
    endfunction

    logic [PW-1:0] presc_r, presc_nxt_s;
    logic          tick_r, tick_nxt_s;
    logic [3:0]    sec_1s_r, sec_10s_r, min_1s_r, min_10s_r, hr_1s_r, hr_10s_r;
    logic [3:0]    sec_1s_nxt_s, sec_10s_nxt_s, min_1s_nxt_s, min_10s_nxt_s;
    logic [3:0]    hr_1s_nxt_s, hr_10s_nxt_s;
    logic          pm_r, pm_nxt_s;
    logic          btn_hr_q_r, btn_min_q_r;
    logic          hr_edge_s, min_edge_s;
    logic [8:0]    sec_inc_s, min_inc_s, hr_inc_s;

    assign hr_edge_s  = bus.btn_hr & ~btn_hr_q_r;
    assign min_edge_s = bus.btn_min & ~btn_min_q_r;
    assign sec_inc_s  = bcd60_inc(sec_10s_r, sec_1s_r);
    assign min_inc_s  = bcd60_inc(min_10s_r, min_1s_r);
    assign hr_inc_s   = hour_inc(hr_10s_r, hr_1s_r, pm_r);

    // Next-state selection: set mode edits, run mode ripples a whole second in one cycle.
    always_comb begin
        presc_nxt_s   = presc_r;
        tick_nxt_s    = 1'b0;
        sec_1s_nxt_s  = sec_1s_r;
        sec_10s_nxt_s = sec_10s_r;
        min_1s_nxt_s  = min_1s_r;
        min_10s_nxt_s = min_10s_r;
        hr_1s_nxt_s   = hr_1s_r;
        hr_10s_nxt_s  = hr_10s_r;
        pm_nxt_s      = pm_r;
        if (bus.set_mode) begin
            presc_nxt_s   = '0;
            sec_1s_nxt_s  = 4'd0;
            sec_10s_nxt_s = 4'd0;
            // Minutes wrap 59->00 here without touching the hour.
            if (min_edge_s) begin
                {min_10s_nxt_s, min_1s_nxt_s} = min_inc_s[7:0];
            end else begin
                {min_10s_nxt_s, min_1s_nxt_s} = {min_10s_r, min_1s_r};
            end
            if (hr_edge_s) begin
                {pm_nxt_s, hr_10s_nxt_s, hr_1s_nxt_s} = hr_inc_s;
            end else begin
                {pm_nxt_s, hr_10s_nxt_s, hr_1s_nxt_s} = {pm_r, hr_10s_r, hr_1s_r};
            end
        end else if (presc_r == PRESC_LAST) begin
            presc_nxt_s = '0;
            tick_nxt_s  = 1'b1;
            {sec_10s_nxt_s, sec_1s_nxt_s} = sec_inc_s[7:0];
            if (sec_inc_s[8]) begin
                {min_10s_nxt_s, min_1s_nxt_s} = min_inc_s[7:0];
                if (min_inc_s[8]) begin
                    {pm_nxt_s, hr_10s_nxt_s, hr_1s_nxt_s} = hr_inc_s;
                end else begin
                    {pm_nxt_s, hr_10s_nxt_s, hr_1s_nxt_s} = {pm_r, hr_10s_r, hr_1s_r};
                end
            end else begin
                {min_10s_nxt_s, min_1s_nxt_s} = {min_10s_r, min_1s_r};
            end
        end else begin
            presc_nxt_s = presc_r + PW'(1);
        end
    end

    // State registers; button history tracks inputs in every mode to avoid stale edges.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc_r     <= '0;
            tick_r      <= 1'b0;
            sec_1s_r    <= 4'd0;
            sec_10s_r   <= 4'd0;
            min_1s_r    <= 4'd0;
            min_10s_r   <= 4'd0;
            hr_1s_r     <= 4'd2;
            hr_10s_r    <= 4'd1;
            pm_r        <= 1'b0;
            btn_hr_q_r  <= 1'b0;
            btn_min_q_r <= 1'b0;
        end else begin
            presc_r     <= presc_nxt_s;
            tick_r      <= tick_nxt_s;
            sec_1s_r    <= sec_1s_nxt_s;
            sec_10s_r   <= sec_10s_nxt_s;
            min_1s_r    <= min_1s_nxt_s;
            min_10s_r   <= min_10s_nxt_s;
            hr_1s_r     <= hr_1s_nxt_s;
            hr_10s_r    <= hr_10s_nxt_s;
            pm_r        <= pm_nxt_s;
            btn_hr_q_r  <= bus.btn_hr;
            btn_min_q_r <= bus.btn_min;
        end
    end

    assign bus.tick_1Hz = tick_r;
    assign bus.sec_1s   = sec_1s_r;
    assign bus.sec_10s  = sec_10s_r;
    assign bus.min_1s   = min_1s_r;
    assign bus.min_10s  = min_10s_r;
    assign bus.hr_1s    = hr_1s_r;
    assign bus.hr_10s   = hr_10s_r;
    assign bus.pm       = pm_r;
endmodule

// File: tb/tb_bcd_time_counter.sv
// Bench for bcd_time_counter: a seconds-of-half-day reference model is stepped
// every clock and compared with the DUT, plus fixed expectations at key points.
module tb_bcd_time_counter;
    localparam int CLK_HZ = 10;

    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    bcd_time_counter_if bus ();

    bcd_time_counter #(.CLK_HZ(CLK_HZ)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad = 0;

    // Reference state: hour index 0..11 (0 shows as 12), minutes, seconds, pm.
    int m_h12 = 0, m_min = 0, m_sec = 0, m_pm = 0;
    int m_presc = 0, m_tick = 0, m_bh_q = 0, m_bm_q = 0;

    logic [25:0] dut_vec;
    assign dut_vec = {bus.pm, bus.tick_1Hz, bus.hr_10s, bus.hr_1s,
                      bus.min_10s, bus.min_1s, bus.sec_10s, bus.sec_1s};

    function automatic logic [25:0] mkvec(input int p, input int t, input int hr,
                                          input int mn, input int sc);
        logic [25:0] v;
        v = {(p != 0), (t != 0), 4'(hr / 10), 4'(hr % 10),
             4'(mn / 10), 4'(mn % 10), 4'(sc / 10), 4'(sc % 10)};
        return v;
    endfunction

    function automatic logic [25:0] exp_vec();
        return mkvec(m_pm, m_tick, (m_h12 == 0) ? 12 : m_h12, m_min, m_sec);
    endfunction

    task automatic model_step();
        int eh;
        int em;
        int t;
        if (reset) begin
            m_h12 = 0; m_min = 0; m_sec = 0; m_pm = 0;
            m_presc = 0; m_tick = 0; m_bh_q = 0; m_bm_q = 0;
        end else begin
            eh = (bus.btn_hr && (m_bh_q == 0)) ? 1 : 0;
            em = (bus.btn_min && (m_bm_q == 0)) ? 1 : 0;
            if (bus.set_mode) begin
                m_presc = 0;
                m_tick = 0;
                m_sec = 0;
                if (em != 0) m_min = (m_min + 1) % 60;
                if (eh != 0) begin
                    m_h12 = (m_h12 + 1) % 12;
                    if (m_h12 == 0) m_pm = 1 - m_pm;
                end
            end else if (m_presc == CLK_HZ - 1) begin
                m_presc = 0;
                m_tick = 1;
                t = (m_h12 * 3600 + m_min * 60 + m_sec + 1) % 43200;
                if (t == 0) m_pm = 1 - m_pm;
                m_h12 = t / 3600;
                m_min = (t / 60) % 60;
                m_sec = t % 60;
            end else begin
                m_presc = m_presc + 1;
                m_tick = 0;
            end
            m_bh_q = bus.btn_hr ? 1 : 0;
            m_bm_q = bus.btn_min ? 1 : 0;
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step();
        #1;
    endtask

    task automatic set_time(input int hr, input int mn, input int p);
        bus.set_mode = 1'b1;
        cycle();
        total++;
        if (dut_vec !== exp_vec()) begin
            bad++;
            $display("FAIL set_enter: got %h want %h", dut_vec, exp_vec());
        end
        for (int k = 0; k < 30 && (m_h12 != hr % 12 || m_pm != p); k++) begin
            bus.btn_hr = 1'b1;
            cycle();
            bus.btn_hr = 1'b0;
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL set_hour: got %h want %h", dut_vec, exp_vec());
            end
        end
        for (int k = 0; k < 60 && m_min != mn; k++) begin
            bus.btn_min = 1'b1;
            cycle();
            bus.btn_min = 1'b0;
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL set_min: got %h want %h", dut_vec, exp_vec());
            end
        end
    endtask

    task automatic test_reset();
        int first_tick;
        int ticks;
        reset = 1'b1;
        repeat (3) cycle();
        reset = 1'b0;
        total++;
        if (dut_vec !== mkvec(0, 0, 12, 0, 0)) begin
            bad++;
            $display("FAIL reset_value: got %h want %h", dut_vec, mkvec(0, 0, 12, 0, 0));
        end
        first_tick = 0;
        ticks = 0;
        for (int i = 1; i <= 35; i++) begin
            cycle();
            if (bus.tick_1Hz === 1'b1) begin
                ticks++;
                if (first_tick == 0) first_tick = i;
            end
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL reset_run: cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        total++;
        if (first_tick != 10 || ticks != 3) begin
            bad++;
            $display("FAIL tick_period: first=%0d count=%0d want first=10 count=3",
                     first_tick, ticks);
        end
    endtask

    task automatic test_carry();
        set_time(12, 0, 0);
        bus.set_mode = 1'b0;
        for (int i = 0; i < 600 * CLK_HZ; i++) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL carry_track: got %h want %h", dut_vec, exp_vec());
            end
        end
        total++;
        if (dut_vec !== mkvec(0, 1, 12, 10, 0)) begin
            bad++;
            $display("FAIL carry_end: got %h want %h", dut_vec, mkvec(0, 1, 12, 10, 0));
        end
    endtask

    task automatic test_ampm();
        set_time(11, 59, 0);
        bus.set_mode = 1'b0;
        repeat (60 * CLK_HZ) cycle();
        total++;
        if (dut_vec !== mkvec(1, 1, 12, 0, 0)) begin
            bad++;
            $display("FAIL ampm_noon: got %h want %h", dut_vec, mkvec(1, 1, 12, 0, 0));
        end
        for (int i = 0; i < 3600 * CLK_HZ; i++) begin
            cycle();
            if (m_tick != 0) begin
                total++;
                if (dut_vec !== exp_vec()) begin
                    bad++;
                    $display("FAIL ampm_track: got %h want %h", dut_vec, exp_vec());
                end
            end
        end
        total++;
        if (dut_vec !== mkvec(1, 1, 1, 0, 0)) begin
            bad++;
            $display("FAIL ampm_one: got %h want %h", dut_vec, mkvec(1, 1, 1, 0, 0));
        end
    endtask

    task automatic test_set_mode();
        set_time(12, 34, 1);
        bus.set_mode = 1'b0;
        repeat (27 * CLK_HZ) cycle();
        total++;
        if (dut_vec !== mkvec(1, 1, 12, 34, 27)) begin
            bad++;
            $display("FAIL set_pre: got %h want %h", dut_vec, mkvec(1, 1, 12, 34, 27));
        end
        bus.set_mode = 1'b1;
        cycle();
        total++;
        if (dut_vec !== mkvec(1, 0, 12, 34, 0)) begin
            bad++;
            $display("FAIL set_clear_sec: got %h want %h", dut_vec, mkvec(1, 0, 12, 34, 0));
        end
        bus.btn_min = 1'b1;
        repeat (20) begin
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL set_held: got %h want %h", dut_vec, exp_vec());
            end
        end
        bus.btn_min = 1'b0;
        cycle();
        total++;
        if (dut_vec !== mkvec(1, 0, 12, 35, 0)) begin
            bad++;
            $display("FAIL set_held_once: got %h want %h", dut_vec, mkvec(1, 0, 12, 35, 0));
        end
        repeat (26) begin
            bus.btn_min = 1'b1;
            cycle();
            bus.btn_min = 1'b0;
            cycle();
        end
        total++;
        if (dut_vec !== mkvec(1, 0, 12, 1, 0)) begin
            bad++;
            $display("FAIL set_min_wrap: got %h want %h", dut_vec, mkvec(1, 0, 12, 1, 0));
        end
    endtask

    task automatic test_simultaneous();
        set_time(11, 59, 0);
        bus.btn_hr = 1'b1;
        bus.btn_min = 1'b1;
        cycle();
        total++;
        if (dut_vec !== mkvec(1, 0, 12, 0, 0)) begin
            bad++;
            $display("FAIL simultaneous: got %h want %h", dut_vec, mkvec(1, 0, 12, 0, 0));
        end
        bus.btn_hr = 1'b0;
        bus.btn_min = 1'b0;
        cycle();
    endtask

    task automatic test_ignored();
        bus.set_mode = 1'b0;
        bus.btn_hr = 1'b1;
        repeat (5) cycle();
        bus.btn_hr = 1'b0;
        repeat (5) cycle();
        total++;
        if (dut_vec !== mkvec(1, 1, 12, 0, 1)) begin
            bad++;
            $display("FAIL ignored_hr: got %h want %h", dut_vec, mkvec(1, 1, 12, 0, 1));
        end
        bus.btn_min = 1'b1;
        cycle();
        bus.set_mode = 1'b1;
        repeat (4) cycle();
        total++;
        if (dut_vec !== mkvec(1, 0, 12, 0, 0)) begin
            bad++;
            $display("FAIL held_into_set: got %h want %h", dut_vec, mkvec(1, 0, 12, 0, 0));
        end
        bus.btn_min = 1'b0;
        cycle();
    endtask

    task automatic test_reset_mid();
        int k;
        set_time(7, 45, 1);
        bus.set_mode = 1'b0;
        k = 0;
        while (k < 1000 && !(m_sec == 59 && m_presc == CLK_HZ - 1)) begin
            cycle();
            k++;
        end
        total++;
        if (dut_vec !== mkvec(1, 0, 7, 45, 59)) begin
            bad++;
            $display("FAIL reset_mid_pre: got %h want %h after %0d cycles",
                     dut_vec, mkvec(1, 0, 7, 45, 59), k);
        end
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        total++;
        if (dut_vec !== mkvec(0, 0, 12, 0, 0)) begin
            bad++;
            $display("FAIL reset_mid: got %h want %h", dut_vec, mkvec(0, 0, 12, 0, 0));
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 149) == 0) bus.set_mode = ~bus.set_mode;
            if ($urandom_range(0, 3) == 0) bus.btn_hr = ~bus.btn_hr;
            if ($urandom_range(0, 3) == 0) bus.btn_min = ~bus.btn_min;
            reset = ($urandom_range(0, 599) == 0);
            cycle();
            total++;
            if (dut_vec !== exp_vec()) begin
                bad++;
                $display("FAIL random: cycle %0d got %h want %h", i, dut_vec, exp_vec());
            end
        end
        reset = 1'b0;
        bus.set_mode = 1'b0;
        bus.btn_hr = 1'b0;
        bus.btn_min = 1'b0;
        cycle();
    endtask

    initial begin
        bus.set_mode = 1'b0;
        bus.btn_hr = 1'b0;
        bus.btn_min = 1'b0;
        #1;
        test_reset();
        test_carry();
        test_ampm();
        test_set_mode();
        test_simultaneous();
        test_ignored();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/bcd_time_counter.md
Name: bcd_time_counter

Overview:
- Timekeeping stage directly upstream of the VGA clock-face renderer.
- Divides the system clock to a 1 Hz tick and keeps 12-hour time as six BCD digits: hr_10s/hr_1s, min_10s/min_1s, sec_10s/sec_1s, plus an AM/PM flag.
- Supports a set mode in which counting halts and debounced buttons advance hours and minutes.
- Digit outputs drive the renderer's digit inputs directly; tick_1Hz drives its optional colon-blink input.

Parameters:
- CLK_HZ, 100_000_000, system clock cycles per second; 10 for simulation.

Ports:
- clk  input  1  system clock (100 MHz on board)
- reset  input  1  synchronous, active-high reset
- set_mode  input  1  level; 1 = halt counting and enable manual set
- btn_hr  input  1  debounced level; each rising edge advances the hour (set_mode only)
- btn_min  input  1  debounced level; each rising edge advances the minute (set_mode only)
- tick_1Hz  output  1  one-cycle pulse, once per second while running
- sec_1s  output  4  BCD 0-9
- sec_10s  output  4  BCD 0-5
- min_1s  output  4  BCD 0-9
- min_10s  output  4  BCD 0-5
- hr_1s  output  4  BCD 0-9
- hr_10s  output  4  BCD 0-1
- pm  output  1  0 = AM, 1 = PM

Behaviour:
- Single clock domain; all state updates on the rising edge of clk. Reset is synchronous and active-high.
- Reset values: time 12:00:00 (hr_10s=1, hr_1s=2, all other digits 0), pm=0, tick_1Hz=0, prescaler=0, button edge registers=0.
- Prescaler: counter of width $clog2(CLK_HZ), counts 0..CLK_HZ-1.
  - On the edge where prescaler==CLK_HZ-1 with set_mode=0: prescaler goes to 0, tick_1Hz registers 1, and time advances one second on that same edge.
  - tick_1Hz is high for exactly one cycle, coincident with the new digit values. Period is exactly CLK_HZ cycles.
- Second advance, with ripple carry in one cycle (no multi-cycle carry):
  - sec_1s 9->0 carries into sec_10s.
  - sec_10s 5->0 carries into minutes.
  - min_1s 9->0 carries into min_10s.
  - min_10s 5->0 carries into hours.
- Hour sequence: 12, 01, 02, ... 11, 12 (never 00, never 13).
  - 09->10 sets hr_10s=1, hr_1s=0.
  - 12->01 sets hr_10s=0, hr_1s=1.
  - 11->12 toggles pm, so 11:59:59 -> 12:00:00 flips AM/PM.
- Set mode (set_mode=1):
  - prescaler held at 0; tick_1Hz=0; sec_10s and sec_1s forced to 0 on every cycle.
  - Rising-edge detect: registered copy btn_x_q; edge = btn_x & ~btn_x_q. The digits show the new value on the cycle after the edge is sampled.
  - btn_min edge: minutes +1, 59->00 wraps with no carry into hours.
  - btn_hr edge: hours +1 using the same 12-hour sequence, including the pm toggle on 11->12.
  - btn_hr and btn_min edges in the same cycle: both applied independently.
  - A held button produces one increment only.
- Button edges while set_mode=0 are ignored; the edge registers still track the inputs, so releasing set_mode with a button held produces no spurious edge later.
- Leaving set_mode (1->0): prescaler restarts from 0, so the first tick arrives CLK_HZ cycles after the first cycle with set_mode=0.
- Entering set_mode mid-second: the partial second is discarded and seconds clear on the next edge.
- Reset asserted at any time, including mid-carry or in set mode, overrides everything and restores the reset values on the next edge.
- All outputs are registered; there are no combinational paths from input to output.
- Digit outputs are always legal BCD within the ranges listed under Ports.

Test Plan (CLK_HZ=10):
- Reset: hold reset 3 cycles, release -> digits read 12:00:00, pm=0. tick_1Hz first rises exactly 10 cycles after reset release, then every 10 cycles, 1 cycle wide.
- Second/minute carry: via set mode, load 12:00 with seconds cleared, then run 600 ticks -> 12:10:00. Check min_10s steps 0->1 on the same edge sec_10s wraps 5->0.
- AM/PM rollover: set 11:59 AM, run 60 ticks -> 12:00:00 with pm=1. Run 3600 more ticks -> 01:00:00, pm=1, hr_10s=0.
- Set mode: set_mode=1 at 12:34:27 -> seconds read 00 next cycle, tick stays 0.
  - btn_min held high 20 cycles -> exactly +1 minute (12:35).
  - 26 separate btn_min pulses -> wraps through 59 to 01 with hour unchanged.
- Simultaneous and ignored buttons:
  - In set mode at 11:59 AM, btn_hr and btn_min rise in the same cycle -> 12:00, pm=1.
  - With set_mode=0, btn_hr pulse -> no change.
- Reset mid-operation: at 07:45:59 PM with prescaler=9, assert reset -> next edge shows 12:00:00 AM, no tick_1Hz pulse.
